// File: rtl/computie_bus_capture_controller.sv
// Trigger-qualified bus record capture: arms on a command, stores a bounded run of
// snooped records starting at the trigger address and drains them through a FIFO.
module computie_bus_capture_controller #(
    parameter int BITWIDTH = 32,
    parameter int DEPTH    = 16,
    localparam int RW      = 2 * BITWIDTH + 2,
    localparam int CW      = $clog2(DEPTH) + 1
) (
    input  logic                comm_clock,
    input  logic                reset,
    input  logic                cmd_arm,
    input  logic                cmd_abort,
    input  logic [BITWIDTH-1:0] trig_addr,
    input  logic [BITWIDTH-1:0] trig_mask,
    input  logic [CW-1:0]       capture_limit,
    input  logic                rec_valid,
    output logic                rec_ready,
    input  logic [RW-1:0]       rec_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [RW-1:0]       out_data,
    output logic                record_start,
    output logic                record_trigger,
    input  logic                record_end,
    output logic                busy,
    output logic                done,
    output logic                overflow,
    output logic [CW-1:0]       count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DRAIN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [RW-1:0]     mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     occ_q, occ_d, count_q, count_d, limit_q, limit_d;
    logic [CW-1:0]     limit_sel_s, occ_after_pop_s;
    logic              overflow_q, overflow_d, trig_q, trig_d;
    logic              record_start_q, busy_q, done_q;
    logic              push_s, pop_s, flush_s, full_s, can_push_s, match_s;
    logic [BITWIDTH-1:0] rec_addr_s;

    assign rec_addr_s      = rec_in[2*BITWIDTH-1:BITWIDTH];
    assign match_s         = ((rec_addr_s ^ trig_addr) & trig_mask) == {BITWIDTH{1'b0}};
    assign full_s          = (occ_q == DEPTH_C);
    assign pop_s           = out_valid & out_ready;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign can_push_s      = ~full_s | pop_s;
    assign occ_after_pop_s = occ_q - CW'(pop_s);
    assign limit_sel_s     = ((capture_limit == {CW{1'b0}}) || (capture_limit > DEPTH_C))
                             ? DEPTH_C : capture_limit;

    // Session control: next state, counters, sticky flags and FIFO write request.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        limit_d    = limit_q;
        overflow_d = overflow_q;
        trig_d     = 1'b0;
        push_s     = 1'b0;
        flush_s    = 1'b0;
        if (cmd_abort) begin
            state_d = S_IDLE;
            count_d = {CW{1'b0}};
            flush_s = 1'b1;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (cmd_arm) begin
                        state_d    = S_ARMED;
                        count_d    = {CW{1'b0}};
                        overflow_d = 1'b0;
                        limit_d    = limit_sel_s;
                    end else begin
                        state_d = state_q;
                    end
                end
                S_ARMED: begin
                    if (rec_valid && match_s) begin
                        push_s  = 1'b1;
                        trig_d  = 1'b1;
                        count_d = CW'(1);
                        state_d = (limit_q == CW'(1)) ? S_DRAIN : S_CAPTURE;
                    end else begin
                        state_d = S_ARMED;
                    end
                end
                S_CAPTURE: begin
                    if (rec_valid && can_push_s) begin
                        push_s  = 1'b1;
                        count_d = count_q + CW'(1);
                    end else if (rec_valid) begin
                        overflow_d = 1'b1;
                    end else begin
                        count_d = count_q;
                    end
                    if (record_end || (count_d == limit_q)) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_CAPTURE;
                    end
                end
                S_DRAIN: begin
                    // Records arriving while the queue is still full count as lost.
                    if (rec_valid && !can_push_s) begin
                        overflow_d = 1'b1;
                    end else begin
                        overflow_d = overflow_q;
                    end
                    if (occ_after_pop_s == {CW{1'b0}}) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // FIFO pointer and occupancy update; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (flush_s) begin
            wr_ptr_d = {AW{1'b0}};
            rd_ptr_d = {AW{1'b0}};
            occ_d    = {CW{1'b0}};
        end else begin
            wr_ptr_d = wr_ptr_q + AW'(push_s);
            rd_ptr_d = rd_ptr_q + AW'(pop_s);
            occ_d    = occ_q + CW'(push_s) - CW'(pop_s);
        end
    end

    // Control and status registers.
    always_ff @(posedge comm_clock or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            wr_ptr_q       <= {AW{1'b0}};
            rd_ptr_q       <= {AW{1'b0}};
            occ_q          <= {CW{1'b0}};
            count_q        <= {CW{1'b0}};
            limit_q        <= DEPTH_C;
            overflow_q     <= 1'b0;
            trig_q         <= 1'b0;
            record_start_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            occ_q          <= occ_d;
            count_q        <= count_d;
            limit_q        <= limit_d;
            overflow_q     <= overflow_d;
            trig_q         <= trig_d;
            record_start_q <= (state_d == S_ARMED) || (state_d == S_CAPTURE);
            busy_q         <= (state_d == S_ARMED) || (state_d == S_CAPTURE) || (state_d == S_DRAIN);
            done_q         <= (state_d == S_DONE);
        end
    end

    // Record storage; contents are meaningless while occupancy is zero.
    always_ff @(posedge comm_clock) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= rec_in;
        end
    end

    assign rec_ready      = 1'b1;
    assign out_valid      = (occ_q != {CW{1'b0}});
    assign out_data       = mem_q[rd_ptr_q];
    assign record_start   = record_start_q;
    assign record_trigger = trig_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign overflow       = overflow_q;
    assign count          = count_q;

endmodule

// File: tb/tb_computie_bus_capture_controller.sv
// Self-checking bench for computie_bus_capture_controller: scenario tasks plus a
// queue scoreboard of records expected to leave the FIFO.
module tb_computie_bus_capture_controller;

    localparam int BW    = 32;
    localparam int DEPTH = 16;
    localparam int RW    = 2 * BW + 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_arm = 1'b0, cmd_abort = 1'b0;
    logic [BW-1:0] trig_addr = '0, trig_mask = '0;
    logic [CW-1:0] capture_limit = '0;
    logic          rec_valid = 1'b0, out_ready = 1'b0, record_end = 1'b0;
    logic [RW-1:0] rec_in = '0;
    logic          rec_ready, out_valid, record_start, record_trigger, busy, done, overflow;
    logic [RW-1:0] out_data;
    logic [CW-1:0] count;

    int n_tests = 0;
    int n_fail  = 0;
    int trig_cnt = 0;
    int pops = 0;
    logic [RW-1:0] exp_q [$];

    computie_bus_capture_controller #(.BITWIDTH(BW), .DEPTH(DEPTH)) dut (
        .comm_clock(clk), .reset(reset), .cmd_arm(cmd_arm), .cmd_abort(cmd_abort),
        .trig_addr(trig_addr), .trig_mask(trig_mask), .capture_limit(capture_limit),
        .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_in(rec_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .record_start(record_start), .record_trigger(record_trigger), .record_end(record_end),
        .busy(busy), .done(done), .overflow(overflow), .count(count)
    );

    always #5 clk = ~clk;

    // One clock: observe pops/trigger at the falling edge, return 1 time unit after the rising edge.
    task automatic step();
        logic [RW-1:0] e;
        @(negedge clk);
        if (record_trigger === 1'b1) trig_cnt++;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            n_tests++;
            pops++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL pop_order: got unexpected record %h, required no pop", out_data);
            end else begin
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    n_fail++;
                    $display("FAIL pop_order: got %h, required %h", out_data, e);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [RW-1:0] mk_rec(input logic [BW-1:0] addr);
        logic [1:0]    m;
        logic [BW-1:0] d;
        m = 2'($urandom_range(0, 3));
        d = $urandom;
        return {m, addr, d};
    endfunction

    task automatic send(input logic [RW-1:0] rec, input logic end_flag);
        rec_in     = rec;
        rec_valid  = 1'b1;
        record_end = end_flag;
        step();
        rec_valid  = 1'b0;
        record_end = 1'b0;
    endtask

    task automatic arm(input logic [BW-1:0] ta, input logic [BW-1:0] tm, input logic [CW-1:0] lim);
        trig_addr     = ta;
        trig_mask     = tm;
        capture_limit = lim;
        cmd_arm       = 1'b1;
        step();
        cmd_arm       = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (done !== 1'b1 && k < budget) begin
            step();
            k++;
        end
        n_tests++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL wait_done: done=%b after %0d cycles, required 1", done, budget);
        end
    endtask

    task automatic test_reset();
        logic [CW+5:0] obs;
        repeat (2) @(posedge clk);
        #1;
        obs = {out_valid, record_start, record_trigger, busy, done, overflow, count};
        n_tests++;
        if (obs !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b, required all zero", obs);
        end
        reset = 1'b0;
        step();
        n_tests++;
        if (rec_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: rec_ready=%b busy=%b, required 1/0", rec_ready, busy);
        end
    endtask

    task automatic test_basic();
        logic [RW-1:0] r;
        logic [BW-1:0] addrs [3];
        addrs[0] = 32'h0000_1000;
        addrs[1] = 32'h0000_1004;
        addrs[2] = 32'h0000_1008;
        out_ready = 1'b1;
        trig_cnt  = 0;
        arm(32'h0000_1000, 32'hFFFF_FFFF, 5'd3);
        n_tests++;
        if (busy !== 1'b1 || record_start !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_armed: busy=%b start=%b done=%b, required 1/1/0", busy, record_start, done);
        end
        send(mk_rec(32'h0000_0FFC), 1'b0);
        n_tests++;
        if (count !== 5'd0 || record_start !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_nomatch: count=%0d start=%b, required 0/1", count, record_start);
        end
        for (int i = 0; i < 3; i++) begin
            r = mk_rec(addrs[i]);
            exp_q.push_back(r);
            send(r, 1'b0);
            if (i == 0) begin
                n_tests++;
                if (record_trigger !== 1'b1 || count !== 5'd1) begin
                    n_fail++;
                    $display("FAIL basic_trigger: trig=%b count=%0d, required 1/1", record_trigger, count);
                end
            end
        end
        n_tests++;
        if (count !== 5'd3 || record_start !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_limit: count=%0d start=%b busy=%b, required 3/0/1", count, record_start, busy);
        end
        send(mk_rec(32'h0000_100C), 1'b0);
        wait_done(20);
        n_tests++;
        if (count !== 5'd3 || trig_cnt != 1 || exp_q.size() != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done: count=%0d trig_pulses=%0d left=%0d busy=%b, required 3/1/0/0",
                     count, trig_cnt, exp_q.size(), busy);
        end
    endtask

    task automatic test_overflow();
        logic [BW-1:0] ta, tm, a;
        logic [CW-1:0] lim;
        logic [RW-1:0] r;
        out_ready = 1'b0;
        ta  = $urandom;
        tm  = $urandom | 32'h0000_0001;
        lim = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(17, 31));
        arm(ta, tm, lim);
        a = (ta & tm) | ($urandom & ~tm);
        r = mk_rec(a);
        exp_q.push_back(r);
        send(r, 1'b0);
        for (int i = 0; i < 20; i++) begin
            r = mk_rec($urandom);
            if (i < 15) exp_q.push_back(r);
            send(r, 1'b0);
        end
        n_tests++;
        if (count !== 5'd16) begin
            n_fail++;
            $display("FAIL ovf_count: got %0d, required 16 (limit %0d)", count, lim);
        end
        n_tests++;
        if (overflow !== 1'b1 || out_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_flags: ovf=%b valid=%b busy=%b done=%b, required 1/1/1/0",
                     overflow, out_valid, busy, done);
        end
        pops = 0;
        out_ready = 1'b1;
        wait_done(40);
        n_tests++;
        if (pops != 16 || exp_q.size() != 0 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_drain: pops=%0d left=%0d ovf=%b, required 16/0/1", pops, exp_q.size(), overflow);
        end
    endtask

    task automatic test_record_end();
        logic [BW-1:0] ta, tm;
        logic [RW-1:0] r;
        out_ready = 1'b0;
        ta = $urandom;
        tm = $urandom;
        arm(ta, tm, 5'($urandom_range(4, 16)));
        r = mk_rec((ta & tm) | ($urandom & ~tm));
        exp_q.push_back(r);
        send(r, 1'b0);
        r = mk_rec($urandom);
        exp_q.push_back(r);
        send(r, 1'b1);
        n_tests++;
        if (count !== 5'd2 || busy !== 1'b1 || record_start !== 1'b0) begin
            n_fail++;
            $display("FAIL end_drain: count=%0d busy=%b start=%b, required 2/1/0", count, busy, record_start);
        end
        pops = 0;
        out_ready = 1'b1;
        wait_done(20);
        n_tests++;
        if (pops != 2 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL end_pops: pops=%0d left=%0d, required 2/0", pops, exp_q.size());
        end
    endtask

    task automatic test_abort();
        logic [BW-1:0] ta, tm;
        logic [RW-1:0] r;
        out_ready = 1'b0;
        ta = $urandom;
        tm = $urandom;
        arm(ta, tm, 5'd0);
        r = mk_rec((ta & tm) | ($urandom & ~tm));
        exp_q.push_back(r);
        send(r, 1'b0);
        for (int i = 0; i < 4; i++) begin
            r = mk_rec($urandom);
            exp_q.push_back(r);
            send(r, 1'b0);
        end
        n_tests++;
        if (count !== 5'd5 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_pre: count=%0d valid=%b, required 5/1", count, out_valid);
        end
        cmd_abort = 1'b1;
        cmd_arm   = 1'b1;
        step();
        cmd_abort = 1'b0;
        cmd_arm   = 1'b0;
        exp_q.delete();
        n_tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || record_start !== 1'b0 || count !== 5'd0) begin
            n_fail++;
            $display("FAIL abort_idle: valid=%b busy=%b start=%b count=%0d, required 0/0/0/0",
                     out_valid, busy, record_start, count);
        end
        arm(ta, tm, 5'd4);
        n_tests++;
        if (busy !== 1'b1 || record_start !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_rearm: busy=%b start=%b, required 1/1", busy, record_start);
        end
        cmd_abort = 1'b1;
        step();
        cmd_abort = 1'b0;
    endtask

    // Higher-level model: first matching record triggers, then records are kept until the limit.
    task automatic run_session();
        logic [BW-1:0] ta, tm, a;
        logic [CW-1:0] lim;
        logic [RW-1:0] r;
        int lim_eff, n, force_pos, stored;
        logic trig, full_run;
        out_ready = 1'b1;
        ta  = $urandom;
        tm  = $urandom & 32'h0000_000F;
        lim = 5'($urandom_range(0, 31));
        lim_eff = (lim == 0 || lim > DEPTH) ? DEPTH : int'(lim);
        n = $urandom_range(4, 30);
        force_pos = $urandom_range(0, n - 1);
        stored = 0;
        trig = 1'b0;
        full_run = 1'b0;
        trig_cnt = 0;
        arm(ta, tm, lim);
        for (int i = 0; i < n; i++) begin
            a = $urandom;
            if (i == force_pos && !trig) a = (ta & tm) | (a & ~tm);
            r = mk_rec(a);
            if (!trig) begin
                if ((a & tm) == (ta & tm)) begin
                    trig = 1'b1;
                    stored = 1;
                    exp_q.push_back(r);
                    if (lim_eff == 1) full_run = 1'b1;
                end
            end else if (!full_run) begin
                stored++;
                exp_q.push_back(r);
                if (stored == lim_eff) full_run = 1'b1;
            end
            send(r, 1'b0);
            repeat ($urandom_range(0, 2)) step();
        end
        if (!full_run) begin
            record_end = 1'b1;
            step();
            record_end = 1'b0;
        end
        wait_done(40);
        n_tests++;
        if (count !== CW'(stored) || trig_cnt != 1 || exp_q.size() != 0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL session: count=%0d trig=%0d left=%0d ovf=%b, required %0d/1/0/0",
                     count, trig_cnt, exp_q.size(), overflow, stored);
        end
    endtask

    task automatic test_reset_mid();
        logic [BW-1:0] ta, tm;
        logic [CW+5:0] obs;
        out_ready = 1'b0;
        ta = $urandom;
        tm = $urandom;
        arm(ta, tm, 5'd0);
        send(mk_rec((ta & tm) | ($urandom & ~tm)), 1'b0);
        send(mk_rec($urandom), 1'b0);
        send(mk_rec($urandom), 1'b0);
        #2;
        reset = 1'b1;
        #1;
        obs = {out_valid, record_start, record_trigger, busy, done, overflow, count};
        n_tests++;
        if (obs !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got %b, required all zero", obs);
        end
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_session();
    endtask

    task automatic test_random_sessions();
        for (int s = 0; s < 8; s++) run_session();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_record_end();
        test_abort();
        test_reset_mid();
        test_random_sessions();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
